// File: rtl/kbd_scan_receiver_pkg.sv
// Shared types and constants for the keyboard scan-code receiver.
// The STOP state is only reachable when KBD_STOP_CHECK_EN is defined.
package kbd_pkg;

    localparam int KBD_DATA_BITS = 8;
    localparam int KBD_SCAN_W    = 8;

    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } kbd_state_t;

endpackage

// File: rtl/kbd_scan_receiver_if.sv
// Signal bundle between the 8042-side serial line / CPU side and the receiver.
// The master drives the serial line and the clear strobe; the slave (receiver)
// drives the holding register and status flags.
interface kbd_scan_receiver_if;
    import kbd_pkg::*;

    logic                  KBD_DATA;
    logic                  KBD_CLEAR;
    logic [KBD_SCAN_W-1:0] KBD_SCAN_CODE;
    logic                  KBD_IRQ;
    logic                  KBD_OVERRUN;
    logic                  KBD_FRAME_ERR;
    logic                  KBD_RX_BUSY;

    modport master (
        output KBD_DATA,
        output KBD_CLEAR,
        input  KBD_SCAN_CODE,
        input  KBD_IRQ,
        input  KBD_OVERRUN,
        input  KBD_FRAME_ERR,
        input  KBD_RX_BUSY
    );

    modport slave (
        input  KBD_DATA,
        input  KBD_CLEAR,
        output KBD_SCAN_CODE,
        output KBD_IRQ,
        output KBD_OVERRUN,
        output KBD_FRAME_ERR,
        output KBD_RX_BUSY
    );

endinterface

// File: rtl/kbd_scan_receiver_serial_shifter.sv
// Serial deserialiser for one scan-code frame: start detect, fixed skip to
// bit0, eight data samples LSB first. Emits a one-cycle byte_valid with the
// assembled byte. With KBD_STOP_CHECK_EN defined a stop bit is sampled one
// cycle after bit7 and a low stop bit produces a frame_err pulse instead.
module kbd_serial_shifter
    import kbd_pkg::*;
#(
    parameter int SKIP_CYCLES = 2,
    parameter int IDLE_MIN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line,
    output logic                  busy,
    output logic                  byte_valid,
    output logic [KBD_SCAN_W-1:0] rx_byte,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(SKIP_CYCLES + 9) + 1;
    localparam int ARM_W = $clog2(IDLE_MIN + 1) + 1;

`ifdef KBD_STOP_CHECK_EN
    // All eight bits must be held until the stop sample decides the frame.
    localparam int SH_W = KBD_DATA_BITS;
`else
    // Bit7 is taken straight from the line on the completion cycle.
    localparam int SH_W = KBD_DATA_BITS - 1;
`endif

    localparam logic [CNT_W-1:0] SKIP_C = CNT_W'(SKIP_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SKIP_CYCLES + KBD_DATA_BITS - 1);
    localparam logic [ARM_W-1:0] IDLE_C = ARM_W'(IDLE_MIN);

    kbd_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ARM_W-1:0]  arm_cnt, arm_cnt_nxt;
    logic [SH_W-1:0]   shreg, shreg_nxt;

    // State, frame counter, re-arm counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARM;
            cnt     <= '0;
            arm_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            arm_cnt <= arm_cnt_nxt;
            shreg   <= shreg_nxt;
        end
    end

`ifdef KBD_STOP_CHECK_EN
    assign rx_byte = shreg;
`else
    assign rx_byte = {line, shreg};
`endif

    // Next-state logic; cnt counts cycles since the start sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        arm_cnt_nxt = arm_cnt;
        shreg_nxt   = shreg;
        busy        = 1'b0;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;

        case (state)
            ARM: begin
                // Require a run of high samples so a low bit7 or a trailing
                // low is never mistaken for the next start bit.
                if (line) begin
                    if (arm_cnt + ARM_W'(1) == IDLE_C) begin
                        state_nxt   = IDLE;
                        arm_cnt_nxt = '0;
                    end else begin
                        arm_cnt_nxt = arm_cnt + ARM_W'(1);
                    end
                end else begin
                    arm_cnt_nxt = '0;
                end
            end

            IDLE: begin
                // The start sample itself already counts as receiving.
                if (!line) begin
                    busy      = 1'b1;
                    state_nxt = START;
                    cnt_nxt   = CNT_W'(1);
                    shreg_nxt = '0;
                end
            end

            START: begin
                // Line level is don't-care until the bit0 sample point.
                busy    = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == SKIP_C) begin
                    shreg_nxt = {line, shreg[SH_W-1:1]};
                    state_nxt = DATA;
                end
            end

            DATA: begin
                busy      = 1'b1;
                cnt_nxt   = cnt + CNT_W'(1);
                shreg_nxt = {line, shreg[SH_W-1:1]};
                if (cnt == LAST_C) begin
`ifdef KBD_STOP_CHECK_EN
                    state_nxt  = STOP;
`else
                    byte_valid = 1'b1;
                    state_nxt  = ARM;
                    cnt_nxt    = '0;
`endif
                end
            end

`ifdef KBD_STOP_CHECK_EN
            STOP: begin
                busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ARM;
                if (line) begin
                    byte_valid = 1'b1;
                end else begin
                    frame_err  = 1'b1;
                end
            end
`endif

            default: begin
                state_nxt = ARM;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/kbd_scan_receiver.sv
// PC-side keyboard receiver: deserialises 8042 scan codes, holds the last
// accepted byte for the CPU, raises IRQ1 while it is pending and flags
// overruns. Define KBD_STOP_CHECK_EN to add stop-bit checking and a
// FRAME_ERR pulse; otherwise FRAME_ERR stays 0.
module kbd_scan_receiver
    import kbd_pkg::*;
#(
    parameter int SKIP_CYCLES = 2,
    parameter int IDLE_MIN    = 1
) (
    input  logic                KBD_CLK,
    input  logic                KBD_RESET_N,
    kbd_scan_receiver_if.slave  bus
);

    logic                  busy;
    logic                  byte_valid;
    logic [KBD_SCAN_W-1:0] rx_byte;
    logic                  sh_frame_err;

    logic [KBD_SCAN_W-1:0] scan_code, scan_code_nxt;
    logic                  irq, irq_nxt;
    logic                  overrun, overrun_nxt;
    logic                  frame_err;

    kbd_serial_shifter #(
        .SKIP_CYCLES (SKIP_CYCLES),
        .IDLE_MIN    (IDLE_MIN)
    ) u_shifter (
        .clk        (KBD_CLK),
        .rst_n      (KBD_RESET_N),
        .line       (bus.KBD_DATA),
        .busy       (busy),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (sh_frame_err)
    );

    // Holding register update: a completing byte beats a same-cycle clear.
    always_comb begin
        scan_code_nxt = scan_code;
        irq_nxt       = irq;
        overrun_nxt   = overrun;

        if (bus.KBD_CLEAR) begin
            irq_nxt     = 1'b0;
            overrun_nxt = 1'b0;
        end

        if (byte_valid) begin
            if (!irq || bus.KBD_CLEAR) begin
                scan_code_nxt = rx_byte;
                irq_nxt       = 1'b1;
            end else begin
                overrun_nxt   = 1'b1;
            end
        end
    end

    // CPU-visible registers; the frame error pulse is aligned with them.
    always_ff @(posedge KBD_CLK or negedge KBD_RESET_N) begin
        if (!KBD_RESET_N) begin
            scan_code <= '0;
            irq       <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            scan_code <= scan_code_nxt;
            irq       <= irq_nxt;
            overrun   <= overrun_nxt;
            frame_err <= sh_frame_err;
        end
    end

    assign bus.KBD_SCAN_CODE = scan_code;
    assign bus.KBD_IRQ       = irq;
    assign bus.KBD_OVERRUN   = overrun;
    assign bus.KBD_FRAME_ERR = frame_err;
    assign bus.KBD_RX_BUSY   = busy;

endmodule

// File: tb/tb_kbd_scan_receiver.sv
// Directed plus randomised bench for kbd_scan_receiver (SKIP_CYCLES=2,
// IDLE_MIN=1). Honours KBD_STOP_CHECK_EN for the stop-bit cases.
module tb_kbd_scan_receiver;

    localparam int SKIP = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference state: what the CPU should see after each completed frame.
    logic [7:0] exp_code;
    logic       exp_irq;
    logic       exp_ovr;
    logic       exp_ferr;

    kbd_scan_receiver_if bus ();

    kbd_scan_receiver #(
        .SKIP_CYCLES (SKIP),
        .IDLE_MIN    (1)
    ) dut (
        .KBD_CLK     (clk),
        .KBD_RESET_N (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".scan_code"}, bus.KBD_SCAN_CODE, exp_code);
        check({tag, ".irq"},       {7'd0, bus.KBD_IRQ},       {7'd0, exp_irq});
        check({tag, ".overrun"},   {7'd0, bus.KBD_OVERRUN},   {7'd0, exp_ovr});
        check({tag, ".frame_err"}, {7'd0, bus.KBD_FRAME_ERR}, {7'd0, exp_ferr});
    endtask

    // One line cycle: drive inputs, check busy mid-cycle, advance past the edge.
    task automatic tick(input logic d, input logic c, input logic busy_exp);
        bus.KBD_DATA  = d;
        bus.KBD_CLEAR = c;
        #2;
        check("rx_busy", {7'd0, bus.KBD_RX_BUSY}, {7'd0, busy_exp});
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: how a finished frame changes the CPU view.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic clr);
        exp_ferr = 1'b0;
        if (!stop_ok) begin
            exp_ferr = 1'b1;
            if (clr) begin
                exp_irq = 1'b0;
                exp_ovr = 1'b0;
            end
        end else if (!exp_irq || clr) begin
            exp_code = b;
            exp_irq  = 1'b1;
            if (clr) exp_ovr = 1'b0;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic model_clear();
        exp_irq  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // Sends start, skip filler, 8 data bits (and stop bit when checked),
    // with clr asserted on the completion cycle, then one tail cycle.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop,
                              input logic clr, input logic tail);
        logic stop_ok;
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i < SKIP; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
`ifdef KBD_STOP_CHECK_EN
        for (int k = 0; k < 8; k++) tick(b[k], 1'b0, 1'b1);
        tick(stop, clr, 1'b1);
        stop_ok = stop;
`else
        for (int k = 0; k < 8; k++) tick(b[k], (k == 7) ? clr : 1'b0, 1'b1);
        // No stop sample in this build: every frame completes at bit7.
        stop_ok = stop | 1'b1;
`endif
        model_frame(b, stop_ok, clr);
        check_outputs(tag);
        tick(tail, 1'b0, 1'b0);
        exp_ferr = 1'b0;
        check({tag, ".frame_err_pulse_end"}, {7'd0, bus.KBD_FRAME_ERR}, 8'd0);
    endtask

    task automatic do_clear(input string tag);
        tick(1'b1, 1'b1, 1'b0);
        model_clear();
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rclr;
        logic       rstop;

        checks        = 0;
        errors        = 0;
        exp_code      = 8'h00;
        exp_irq       = 1'b0;
        exp_ovr       = 1'b0;
        exp_ferr      = 1'b0;
        rst_n         = 1'b0;
        bus.KBD_DATA  = 1'b1;
        bus.KBD_CLEAR = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.rx_busy", {7'd0, bus.KBD_RX_BUSY}, 8'd0);
        rst_n = 1'b1;

        // Basic frame after 4 idle cycles
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        send_frame("f1c", 8'h1C, 1'b1, 1'b0, 1'b1);

        // All-zero frame with trailing low must not restart reception
        do_clear("clr1");
        send_frame("f00", 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check_outputs("trailing_low");
        do_clear("clr2");
        send_frame("f9e", 8'h9E, 1'b1, 1'b0, 1'b1);

        // Overrun then clear
        do_clear("clr3");
        send_frame("f2a", 8'h2A, 1'b1, 1'b0, 1'b1);
        send_frame("f3b_overrun", 8'h3B, 1'b1, 1'b0, 1'b1);
        do_clear("clr_overrun");

        // Clear coinciding with completion while overrun is set
        send_frame("f2a_b", 8'h2A, 1'b1, 1'b0, 1'b1);
        send_frame("f3b_b", 8'h3B, 1'b1, 1'b0, 1'b1);
        send_frame("f45_collide", 8'h45, 1'b1, 1'b1, 1'b1);

        // Clear with nothing pending
        do_clear("clr4");
        do_clear("clr_idle");

`ifdef KBD_STOP_CHECK_EN
        // Stop-bit handling
        send_frame("f5a_badstop", 8'h5A, 1'b0, 1'b0, 1'b1);
        send_frame("f5a_goodstop", 8'h5A, 1'b1, 1'b0, 1'b1);
        do_clear("clr5");
`endif

        // Randomised frames against the reference
        for (int n = 0; n < 24; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rclr  = ($urandom_range(0, 3) == 0);
`ifdef KBD_STOP_CHECK_EN
            rstop = ($urandom_range(0, 3) != 0);
`else
            rstop = 1'b1;
`endif
            send_frame("rand", rb, rstop, rclr, 1'b1);
            if ($urandom_range(0, 2) == 0) do_clear("rand_clr");
            repeat ($urandom_range(0, 2)) tick(1'b1, 1'b0, 1'b0);
        end

        // Reset during bit3 of 0xFF with a byte pending
        send_frame("f77", 8'h77, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i < SKIP; i++) tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1);
        bus.KBD_DATA = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_code = 8'h00;
        exp_irq  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        check_outputs("async_reset");
        check("async_reset.rx_busy", {7'd0, bus.KBD_RX_BUSY}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        send_frame("f01_after_reset", 8'h01, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
